// File: rtl/lab_cfg_pkg.sv
// Shared types and constants for the LAB configuration loader.
// LAB_CFG_READBACK_EN adds the VERIFY state used by CRC readback.
package lab_cfg_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

`ifdef LAB_CFG_READBACK_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SHIFT  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd4
  } state_t;
`endif

  // One step of an MSB-first CRC-16 register with serial input din.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/lab_cfg_crc16.sv
// Bit-serial CRC-16 accumulator: clear loads CRC_INIT, enable folds in one bit.
import lab_cfg_pkg::*;

module lab_cfg_crc16 (
  input  logic        clk,
  input  logic        srst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      crc_reg <= '0;
    end else if (clear) begin
      crc_reg <= CRC_INIT;
    end else if (en) begin
      crc_reg <= crc16_step(crc_reg, din);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/lab_config_loader.sv
// Streams bitstream words LSB-first into a LAB scan chain of CHAIN_LEN bits.
// Define LAB_CFG_READBACK_EN to add a recirculating CRC readback check (VERIFY).
import lab_cfg_pkg::*;

module lab_config_loader #(
  parameter int CHAIN_LEN = 256,
  parameter int WORD_W    = 16
) (
  input  logic              config_clk,
  input  logic              config_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_in,
  output logic              cfg_en,
  input  logic              cfg_out,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] word_reg;
  logic [BW-1:0]     bit_idx_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              done_reg;
  logic              error_reg;

  logic load_word;
  logic shift_en;
  logic cnt_en;
  logic start_accept;
  logic last_chain_bit;
  logic last_word_bit;

  assign last_chain_bit = (bit_cnt_reg == CNT_W'(CHAIN_LEN - 1));
  assign last_word_bit  = (bit_idx_reg == BW'(WORD_W - 1));
  assign start_accept   = (state_reg == IDLE) && start && !abort;

`ifdef LAB_CFG_READBACK_EN
  logic        verify_en;
  logic [15:0] crc_tx;
  logic [15:0] crc_rx;

  assign cnt_en = shift_en | verify_en;

  lab_cfg_crc16 u_crc_tx (
    .clk   (config_clk),
    .srst  (config_rst),
    .clear (start_accept),
    .en    (shift_en),
    .din   (cfg_in),
    .crc   (crc_tx)
  );

  lab_cfg_crc16 u_crc_rx (
    .clk   (config_clk),
    .srst  (config_rst),
    .clear (start_accept),
    .en    (verify_en),
    .din   (cfg_out),
    .crc   (crc_rx)
  );

  assign busy = (state_reg == FETCH) || (state_reg == SHIFT) || (state_reg == VERIFY);
`else
  logic unused_cfg_out;
  assign unused_cfg_out = cfg_out;
  assign cnt_en         = shift_en;
  assign busy           = (state_reg == FETCH) || (state_reg == SHIFT);
`endif

  always_comb begin
    state_next = state_reg;
    word_ready = 1'b0;
    cfg_en     = 1'b0;
    cfg_in     = 1'b0;
    load_word  = 1'b0;
    shift_en   = 1'b0;
`ifdef LAB_CFG_READBACK_EN
    verify_en  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          load_word  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        cfg_en   = 1'b1;
        cfg_in   = word_reg[0];
        shift_en = 1'b1;
        if (last_chain_bit) begin
`ifdef LAB_CFG_READBACK_EN
          state_next = VERIFY;
`else
          state_next = DONE;
`endif
        end else if (last_word_bit) begin
          // Prefetch the next word on the final bit so shifting has no bubble.
          word_ready = 1'b1;
          if (word_valid) load_word = 1'b1;
          else            state_next = FETCH;
        end
      end
`ifdef LAB_CFG_READBACK_EN
      VERIFY: begin
        // Feed the tail back to the head so a full pass restores the chain.
        cfg_en    = 1'b1;
        cfg_in    = cfg_out;
        verify_en = 1'b1;
        if (last_chain_bit) state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort and reset override everything; the chain must never see cfg_en then.
    if (abort || config_rst) begin
      state_next = IDLE;
      word_ready = 1'b0;
      cfg_en     = 1'b0;
      cfg_in     = 1'b0;
      load_word  = 1'b0;
      shift_en   = 1'b0;
`ifdef LAB_CFG_READBACK_EN
      verify_en  = 1'b0;
`endif
    end
  end

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state_reg   <= IDLE;
      word_reg    <= '0;
      bit_idx_reg <= '0;
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (abort) begin
        error_reg <= 1'b1;
        done_reg  <= 1'b0;
      end else if (start_accept) begin
        done_reg  <= 1'b0;
        error_reg <= 1'b0;
      end else if (state_reg == DONE) begin
        done_reg <= 1'b1;
`ifdef LAB_CFG_READBACK_EN
        if (crc_tx != crc_rx) error_reg <= 1'b1;
`endif
      end

      if (load_word) begin
        word_reg    <= word_data;
        bit_idx_reg <= '0;
      end else if (shift_en) begin
        word_reg    <= word_reg >> 1;
        bit_idx_reg <= bit_idx_reg + BW'(1);
      end

      // Wraps to zero after the last bit so VERIFY starts a fresh count.
      if (start_accept) begin
        bit_cnt_reg <= '0;
      end else if (cnt_en) begin
        bit_cnt_reg <= last_chain_bit ? '0 : bit_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign done  = done_reg;
  assign error = error_reg;

endmodule
